// File: rtl/capture_mc_pkg.sv
// capture_mc_pkg
//   Shared types for the multi-channel echo pulse-width capture block.
//   - chan_state_e : per-channel FSM state (DISARMED, IDLE, MEASURE)
//   - result_t     : one queued measurement {cnt, ovf, lost}. The cnt field
//                    is MAX_CNT_W wide. Users place their CNT_W-bit count in
//                    the low bits, so CNT_W must not exceed MAX_CNT_W.
//   - chan_idx_w() : width of a channel index, never less than 1 bit.
package capture_mc_pkg;

  localparam int MAX_CNT_W = 32;

  typedef enum logic [1:0] {
    DISARMED = 2'd0,
    IDLE     = 2'd1,
    MEASURE  = 2'd2
  } chan_state_e;

  typedef struct packed {
    logic [MAX_CNT_W-1:0] cnt;
    logic                 ovf;
    logic                 lost;
  } result_t;

  function automatic int chan_idx_w(input int num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

endpackage

// File: rtl/capture_mc_chan.sv
// capture_mc_chan
//   One echo channel. It synchronises the asynchronous echo input, can
//   optionally deglitch it, and measures the high time with a saturating
//   counter. It holds a single result slot with pending and lost tracking.
//   Optional feature macro: CAPTURE_MC_DEGLITCH_EN. When this macro is
//   defined, a stability filter of DEGLITCH cycles sits between the
//   synchroniser and the FSM.
// Ports
//   clk, rst    : clock, asynchronous active-high reset
//   cap_i       : asynchronous echo input
//   chan_en_i   : arm enable. Low discards any measurement in progress.
//   grant_i     : the arbiter is taking result_o this cycle
//   pending_o   : result_o holds an unread measurement
//   result_o    : queued measurement {cnt, ovf, lost}
module capture_mc_chan
  import capture_mc_pkg::*;
#(
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2,
  parameter int DEGLITCH    = 3
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    cap_i,
  input  logic    chan_en_i,
  input  logic    grant_i,
  output logic    pending_o,
  output result_t result_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [SYNC_STAGES-1:0] sync_q;
  // Fills with ones after reset. It marks when sync_q holds only real input
  // samples and none of the zeros that reset loaded.
  logic [SYNC_STAGES-1:0] sync_vld_q;
  logic                   s;
  logic                   lvl;    // level seen by the FSM
  logic                   quiet;  // input known to be low, so arming is safe

  chan_state_e      state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             ovf_q;
  logic             pending_q;
  result_t          res_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q     <= '0;
      sync_vld_q <= '0;
    end else begin
      sync_q     <= {sync_q[SYNC_STAGES-2:0], cap_i};
      sync_vld_q <= {sync_vld_q[SYNC_STAGES-2:0], 1'b1};
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

`ifdef CAPTURE_MC_DEGLITCH_EN
  localparam int DG_W = $clog2(DEGLITCH + 1);

  logic            filt_q;
  logic [DG_W-1:0] stab_q;

  // filt_q follows s only after s has differed from it for DEGLITCH
  // consecutive cycles. Any return to agreement restarts the run.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      filt_q <= 1'b0;
      stab_q <= '0;
    end else if (s != filt_q) begin
      if (stab_q == DG_W'(DEGLITCH - 1)) begin
        filt_q <= s;
        stab_q <= '0;
      end else begin
        stab_q <= stab_q + 1'b1;
      end
    end else begin
      stab_q <= '0;
    end
  end

  assign lvl   = filt_q;
  assign quiet = sync_vld_q[SYNC_STAGES-1] && !s && !filt_q && (stab_q == '0);
`else
  localparam int unused_deglitch = DEGLITCH;

  assign lvl   = s;
  assign quiet = sync_vld_q[SYNC_STAGES-1] && !s;
`endif

  // NOTE: every register below is assigned with <= so that all of them
  // update together from the pre-edge values. With that rule, a later
  // assignment in the block overrides an earlier one in the same cycle.
  // The grant clear of pending_q and a same-cycle new result depend on this.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= DISARMED;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
      pending_q <= 1'b0;
      res_q     <= '0;
    end else begin
      if (grant_i) pending_q <= 1'b0;

      if (!chan_en_i) begin
        state_q <= DISARMED;
        cnt_q   <= '0;
        ovf_q   <= 1'b0;
      end else begin
        unique case (state_q)
          DISARMED: if (quiet) state_q <= IDLE;
          IDLE: begin
            if (lvl) begin
              state_q <= MEASURE;
              cnt_q   <= CNT_W'(1);
              ovf_q   <= 1'b0;
            end
          end
          MEASURE: begin
            if (lvl) begin
              if (cnt_q == CNT_MAX) ovf_q <= 1'b1;
              else                  cnt_q <= cnt_q + 1'b1;
            end else begin
              // When the old result is granted in this same cycle, it is
              // transferred and nothing is lost.
              res_q     <= '{cnt:  MAX_CNT_W'(cnt_q),
                             ovf:  ovf_q,
                             lost: pending_q && !grant_i};
              pending_q <= 1'b1;
              state_q   <= IDLE;
            end
          end
          default: state_q <= DISARMED;
        endcase
      end
    end
  end

  assign pending_o = pending_q;
  assign result_o  = res_q;

endmodule

// File: rtl/capture_mc.sv
// capture_mc
//   Multi-channel ultrasonic echo pulse-width capture. There are NUM_CH
//   independent channels. A round-robin arbiter drains them onto a single
//   registered valid/ready result stream.
//   Optional feature macro: CAPTURE_MC_DEGLITCH_EN. It enables a per-channel
//   stability filter of DEGLITCH cycles.
// Ports
//   clk, rst    : clock, asynchronous active-high reset
//   cap_signal  : asynchronous echo inputs, one per channel
//   chan_en     : per-channel arm enable
//   out_valid   : result available
//   out_ready   : consumer accepts the result
//   out_ch      : channel index of the result
//   out_cnt     : measured high time in clk cycles
//   out_ovf     : count saturated
//   out_lost    : an earlier unread result on this channel was overwritten
module capture_mc
  import capture_mc_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2,
  parameter int DEGLITCH    = 3
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_CH-1:0]             cap_signal,
  input  logic [NUM_CH-1:0]             chan_en,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [chan_idx_w(NUM_CH)-1:0] out_ch,
  output logic [CNT_W-1:0]              out_cnt,
  output logic                          out_ovf,
  output logic                          out_lost
);

  localparam int CH_W = chan_idx_w(NUM_CH);

  logic [NUM_CH-1:0] pending;
  logic [NUM_CH-1:0] grant;
  result_t           res [NUM_CH];

  for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
    capture_mc_chan #(
      .CNT_W       (CNT_W),
      .SYNC_STAGES (SYNC_STAGES),
      .DEGLITCH    (DEGLITCH)
    ) u_chan (
      .clk       (clk),
      .rst       (rst),
      .cap_i     (cap_signal[g]),
      .chan_en_i (chan_en[g]),
      .grant_i   (grant[g]),
      .pending_o (pending[g]),
      .result_o  (res[g])
    );
  end

  logic            out_valid_q;
  logic [CH_W-1:0] out_ch_q;
  logic [CNT_W-1:0] out_cnt_q;
  logic            out_ovf_q;
  logic            out_lost_q;
  logic [CH_W-1:0] ptr_q;

  logic            advance;
  logic            found;
  logic [CH_W-1:0] gnt_idx;
  result_t         sel_res;

  // Round-robin search. It takes the first pending channel at or after
  // ptr_q. The output register can take a new result when it is empty or
  // when its current result is being accepted.
  // NOTE: every signal gets a default at the top of the always_comb block.
  // Any path that skipped an assignment would otherwise infer a latch.
  always_comb begin
    found   = 1'b0;
    gnt_idx = '0;
    grant   = '0;
    advance = !out_valid_q || out_ready;
    for (int k = 0; k < NUM_CH; k++) begin
      if (!found && pending[(int'(ptr_q) + k) % NUM_CH]) begin
        found   = 1'b1;
        gnt_idx = CH_W'((int'(ptr_q) + k) % NUM_CH);
      end
    end
    if (advance && found) grant[gnt_idx] = 1'b1;
  end

  assign sel_res = res[gnt_idx];

  // Count bits above CNT_W are always zero. This signal exists only so that
  // those bits are read.
  logic unused_cnt_hi;
  assign unused_cnt_hi = ^(sel_res.cnt >> CNT_W);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_ch_q    <= '0;
      out_cnt_q   <= '0;
      out_ovf_q   <= 1'b0;
      out_lost_q  <= 1'b0;
      ptr_q       <= '0;
    end else if (advance) begin
      if (found) begin
        out_valid_q <= 1'b1;
        out_ch_q    <= gnt_idx;
        out_cnt_q   <= sel_res.cnt[CNT_W-1:0];
        out_ovf_q   <= sel_res.ovf;
        out_lost_q  <= sel_res.lost;
        ptr_q       <= (gnt_idx == CH_W'(NUM_CH - 1)) ? '0 : gnt_idx + 1'b1;
      end else begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_ch    = out_ch_q;
  assign out_cnt   = out_cnt_q;
  assign out_ovf   = out_ovf_q;
  assign out_lost  = out_lost_q;

endmodule

// File: doc/capture_mc.md
Name: capture_mc

Overview:
- Multi-channel successor to the single-channel pulse-width capture for ultrasonic echo ranging.
- Each channel synchronises its asynchronous echo input and measures high-time in clk cycles with a saturating counter.
- Each channel queues one result; a round-robin arbiter drains results onto a single valid/ready stream consumed by the ranging/UART path.
- No result is silently dropped: overwrites and saturation are flagged.

Parameters:
- NUM_CH, 4, number of echo channels (1..16).
- CNT_W, 16, counter/result width in bits.
- SYNC_STAGES, 2, synchroniser flops per input (>=2).
- DEGLITCH, 3, required stable cycles; used only with CAPTURE_MC_DEGLITCH_EN.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- cap_signal  input  NUM_CH  asynchronous echo inputs, one bit per channel.
- chan_en  input  NUM_CH  per-channel arm enable.
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts result.
- out_ch  output  max(1,$clog2(NUM_CH))  channel index of result.
- out_cnt  output  CNT_W  measured high-time in cycles.
- out_ovf  output  1  count saturated.
- out_lost  output  1  an earlier unread result on this channel was overwritten.

Behaviour:
- Reset: all synchronisers 0; every channel in DISARMED; counters 0; pending flags 0; out_valid=0, out_ch=0, out_cnt=0, out_ovf=0, out_lost=0; round-robin pointer=0.
- Per-channel FSM, operating on the synchronised signal s:
  - DISARMED: go to IDLE when chan_en=1 and s=0. A channel enabled while s is high waits for low, so it never measures a partial pulse.
  - IDLE: on s=1, go to MEASURE with cnt=1.
  - MEASURE: while s=1, cnt increments, saturating at 2^CNT_W-1 with ovf=1. On s=0, copy cnt/ovf to the result register, set pending, and go to IDLE.
  - chan_en=0 in any state: go to DISARMED and discard the in-progress count. An already pending result is kept.
- Count semantics: a pulse high for N synchronised cycles yields cnt=N for N < 2^CNT_W. Longer pulses yield all-ones with ovf=1.
- Latency: an input edge reaches s after SYNC_STAGES cycles. Pending is set on the cycle s is first seen low.
- Overwrite: a new result on a channel whose pending is still set replaces the result and sets that channel's lost flag. The lost flag clears when the result is transferred to the output.
- Same-cycle grant and new result on one channel: the old result is transferred, the new result becomes pending, lost=0.
- Arbiter:
  - Evaluated when out_valid=0, or when out_valid and out_ready are both 1.
  - Grants the first pending channel at or after the pointer; the pointer then moves to granted+1, wrapping at NUM_CH.
  - The granted result loads the registered outputs the next cycle, and that channel's pending clears.
  - Back-to-back transfers reach one result per cycle.
- Output stream: while out_valid=1 and out_ready=0, all out_* hold stable. out_valid drops only after a handshake with no pending channel.
- rst mid-pulse: everything returns to reset values immediately; the pulse in progress is discarded (the channel is DISARMED until input low).

Optional Feature:
- CAPTURE_MC_DEGLITCH_EN.
- Defined: each channel adds a stability filter after the synchroniser. The filtered level changes only after s has differed from it for DEGLITCH consecutive cycles.
  - Latency grows by DEGLITCH cycles on both edges, so measured width is unchanged for clean pulses.
  - Pulses or gaps shorter than DEGLITCH cycles are ignored.
- Undefined: no filter; FSM uses s directly; DEGLITCH is unused.

Decomposition:
- Package capture_mc_pkg: channel FSM state enum (DISARMED, IDLE, MEASURE), a result struct {cnt, ovf, lost}, and a function computing channel-index width.
- One sub-module capture_mc_chan: synchroniser, optional deglitch, FSM, saturating counter, result/pending/lost registers.
- Top level instantiates NUM_CH copies plus the round-robin arbiter and output register.

Test Plan:
- Reset then chan_en=1, ch0 high 10 cycles, out_ready=1 -> one transfer: out_ch=0, out_cnt=10, ovf=0, lost=0.
- CNT_W=4, ch1 high 40 cycles -> out_cnt=15, out_ovf=1.
- ch0 and ch2 fall in the same cycle, pointer=0 -> transfers ch0 then ch2 on consecutive cycles. A later simultaneous pair, pointer=1, yields ch2 first.
- out_ready=0, ch3 pulses of 5 then 7 cycles -> out_valid holds the 5-cycle result stable. After ready: cnt=5, then cnt=7 with lost=1 only if the 7-cycle result overwrote a pending one (check both orderings).
- ch0 high when chan_en rises, falls after 8 cycles, then a 6-cycle pulse -> single result cnt=6. Dropping chan_en mid-pulse -> no result.
- CAPTURE_MC_DEGLITCH_EN, DEGLITCH=3: 2-cycle glitch -> no result. 9-cycle pulse containing a 1-cycle low dropout -> one result cnt=9.
